// File: rtl/mem_init_pkg.sv
// Shared definitions for the data-memory initiator: default sizes, FSM state
// encoding and request-rejection causes.
package mem_init_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int DATA_W_DEF  = 32;
    localparam int MAX_LEN_DEF = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_ALIGN,
        CAUSE_WR_BURST,
        CAUSE_OVERRUN
    } err_cause_e;

endpackage

// File: rtl/mem_req_check.sv
// Request qualifier: byte-to-word address conversion and the acceptance checks
// (alignment, store burst, read overrun past the top word), in priority order.
module mem_req_check
    import mem_init_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = 2
) (
    input  logic              req_write_i,
    input  logic [ADDR_W+1:0] byte_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] word_addr_o,
    output logic              err_o
);

    localparam int MEM_TOP = 2**ADDR_W - 1;

    logic [ADDR_W:0] end_addr;
    err_cause_e      cause;

    assign word_addr_o = byte_addr_i[ADDR_W+1:2];
    // One extra bit so a burst running past the top word is seen, not wrapped.
    assign end_addr    = {1'b0, word_addr_o} + {{(ADDR_W+1-LEN_W){1'b0}}, len_i};

    always_comb begin
        cause = CAUSE_NONE;
        if (byte_addr_i[1:0] != 2'b00) begin
            cause = CAUSE_ALIGN;
        end else if (req_write_i && (len_i != '0)) begin
            cause = CAUSE_WR_BURST;
        end else if (!req_write_i && (end_addr > (ADDR_W+1)'(MEM_TOP))) begin
            cause = CAUSE_OVERRUN;
        end
    end

    assign err_o = (cause != CAUSE_NONE);

endmodule

// File: rtl/mem_initiator.sv
// Requester-side controller for the word-addressed data memory: accepts
// load/store requests, sequences read bursts and returns one response per word.
module mem_initiator
    import mem_init_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W+1:0]          req_addr,
    input  logic [$clog2(MAX_LEN)-1:0] req_len,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_last,
    output logic                       resp_err,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_writeData,
    output logic                       mem_memwrite,
    output logic                       mem_memread,
    input  logic [DATA_W-1:0]          mem_out32
);

    localparam int LEN_W = $clog2(MAX_LEN);

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_last_q, resp_last_d;
    logic              resp_err_q, resp_err_d;

    logic              req_fire;
    logic [ADDR_W-1:0] word_addr;
    logic              req_err;

    mem_req_check #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_check (
        .req_write_i (req_write),
        .byte_addr_i (req_addr),
        .len_i       (req_len),
        .word_addr_o (word_addr),
        .err_o       (req_err)
    );

    assign req_ready = (state_q == S_IDLE);
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path through the case leaves one unassigned (which would infer a latch).
        state_d       = state_q;
        beat_d        = beat_q;
        len_d         = len_q;
        base_d        = base_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        resp_rdata_d  = resp_rdata_q;
        resp_last_d   = resp_last_q;
        resp_err_d    = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    beat_d = '0;
                    len_d  = req_len;
                    base_d = word_addr;
                    if (req_err) begin
                        // Rejected requests leave the memory-side outputs untouched.
                        state_d      = S_ERR;
                        resp_rdata_d = '0;
                        resp_last_d  = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_write) begin
                        state_d       = S_WR;
                        mem_address_d = word_addr;
                        mem_wdata_d   = req_wdata;
                    end else begin
                        state_d       = S_RD_ISSUE;
                        mem_address_d = word_addr;
                    end
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_rdata_d = '0;
                resp_last_d  = 1'b1;
                resp_err_d   = 1'b0;
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d      = S_RESP;
                resp_rdata_d = mem_out32;
                resp_last_d  = (beat_q == len_q);
                resp_err_d   = 1'b0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    if (resp_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d       = S_RD_ISSUE;
                        beat_d        = beat_q + LEN_W'(1);
                        mem_address_d = base_q + ADDR_W'(beat_q + LEN_W'(1));
                    end
                end
            end
            S_ERR: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            len_q         <= '0;
            base_q        <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            resp_rdata_q  <= '0;
            resp_last_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
            state_q       <= state_d;
            beat_q        <= beat_d;
            len_q         <= len_d;
            base_q        <= base_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_last_q   <= resp_last_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // Strobes and resp_valid decode straight from state so reset drops them at once.
    assign mem_memwrite  = (state_q == S_WR);
    assign mem_memread   = (state_q == S_RD_ISSUE);
    assign resp_valid    = (state_q == S_RESP) || (state_q == S_ERR);
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_wdata_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_last     = resp_last_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed and randomized bench for mem_initiator with a word-memory model and
// a transaction-level reference of expected responses.
module tb_mem_initiator;
    import mem_init_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_last, resp_err;
    logic [31:0] resp_rdata;
    logic [5:0]  mem_address;
    logic [31:0] mem_writeData, mem_out32;
    logic        mem_memwrite, mem_memread;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_last     (resp_last),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_out32     (mem_out32)
    );

    // Power-up contents of words never written.
    function automatic logic [31:0] init_word(input int a);
        return 32'h5A00_0000 | (a * 32'h0001_0101);
    endfunction

    // Memory model with registered read data, plus strobe logging.
    logic [31:0] mem_arr [64];
    bit          mem_vld [64];
    logic [5:0]  rd_log [$];
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [5:0]  last_wa;
    logic [31:0] last_wd;

    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem_arr[mem_address] = mem_writeData;
            mem_vld[mem_address] = 1'b1;
            wr_cnt++;
            last_wa = mem_address;
            last_wd = mem_writeData;
        end
        if (mem_memread) begin
            mem_out32 <= mem_vld[mem_address] ? mem_arr[mem_address] : init_word(int'(mem_address));
            rd_log.push_back(mem_address);
        end
        if (mem_memread && mem_memwrite) both_cnt++;
    end

    // Reference memory image seen by the requester.
    logic [31:0] ref_mem [64];
    bit          ref_vld [64];

    function automatic logic [31:0] ref_word(input int a);
        return ref_vld[a] ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and consumes all its response beats; optionally holds
    // resp_ready low for stall_cyc cycles on beat stall_beat.
    task automatic do_req(input bit wr, input logic [7:0] addr, input logic [1:0] len,
                          input logic [31:0] wd, input int stall_beat, input int stall_cyc);
        err_cause_e cause;
        int wa, n_beats, rd0, wr0, lat, n, exp_lat;
        logic [31:0] exp_data, hold_data;
        logic        exp_last, hold_last;
        wa = int'(addr[7:2]);
        if (addr[1:0] != 2'b00)            cause = CAUSE_ALIGN;
        else if (wr && len != 2'd0)        cause = CAUSE_WR_BURST;
        else if (!wr && wa + int'(len) > 63) cause = CAUSE_OVERRUN;
        else                               cause = CAUSE_NONE;
        n_beats = (cause != CAUSE_NONE || wr) ? 1 : int'(len) + 1;

        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_req", req_ready, 1'b1);
        if (!req_ready) return;

        rd0       = rd_log.size();
        wr0       = wr_cnt;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_len   = ~len;
        req_wdata = ~wd;
        req_write = ~wr;

        for (int b = 0; b < n_beats; b++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!resp_valid && lat < 20);
            if (b > 0)                         exp_lat = 3;
            else if (cause != CAUSE_NONE)      exp_lat = 1;
            else if (wr)                       exp_lat = 2;
            else                               exp_lat = 3;
            check("resp_latency", lat, exp_lat);
            if (!resp_valid) return;

            exp_data = (cause == CAUSE_NONE && !wr) ? ref_word(wa + b) : 32'h0;
            exp_last = (b == n_beats - 1);
            check("resp_err",   resp_err,   (cause != CAUSE_NONE));
            check("resp_last",  resp_last,  exp_last);
            check("resp_rdata", resp_rdata, exp_data);
            check("req_ready_busy", req_ready, 1'b0);

            if (b == stall_beat) begin
                hold_data = resp_rdata;
                hold_last = resp_last;
                n = rd_log.size();
                repeat (stall_cyc) begin
                    @(negedge clk);
                    check("stall_valid", resp_valid, 1'b1);
                    check("stall_rdata", resp_rdata, hold_data);
                    check("stall_last",  resp_last,  hold_last);
                    check("stall_no_read", rd_log.size(), n);
                end
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
        end

        @(negedge clk);
        check("req_ready_after", req_ready, 1'b1);
        check("resp_valid_after", resp_valid, 1'b0);
        check("read_strobes", rd_log.size() - rd0, (cause == CAUSE_NONE && !wr) ? int'(len) + 1 : 0);
        check("write_strobes", wr_cnt - wr0, (cause == CAUSE_NONE && wr) ? 1 : 0);
        if (cause == CAUSE_NONE && wr) begin
            check("write_addr", last_wa, wa);
            check("write_data", last_wd, wd);
            ref_mem[wa] = wd;
            ref_vld[wa] = 1'b1;
        end
        if (cause == CAUSE_NONE && !wr) begin
            for (int i = 0; i <= int'(len) && rd0 + i < rd_log.size(); i++)
                check("read_addr", rd_log[rd0 + i], wa + i);
        end
    endtask

    initial begin
        int rd0, lat;
        logic [7:0] a;
        logic [1:0] l;
        bit w;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b0;

        #2;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_last",  resp_last,  1'b0);
        check("rst_resp_err",   resp_err,   1'b0);
        check("rst_memwrite",   mem_memwrite, 1'b0);
        check("rst_memread",    mem_memread,  1'b0);
        check("rst_mem_address", mem_address, 6'd0);
        check("rst_mem_wdata",  mem_writeData, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_req_ready",  req_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then single-word load at word 4.
        do_req(1'b1, 8'h10, 2'd0, 32'hDEADBEEF, -1, 0);
        do_req(1'b0, 8'h10, 2'd0, 32'h0, -1, 0);

        // Top four words, then a burst ending exactly at the last word.
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 8'hF0 + 8'(4 * i), 2'd0, 32'hA0 + i, -1, 0);
        do_req(1'b0, 8'hF0, 2'd3, 32'h0, -1, 0);
        @(negedge clk);
        check("idle_addr_hold", mem_address, 6'd63);

        // Rejected requests: overrun, misaligned, store burst.
        do_req(1'b0, 8'hF4, 2'd3, 32'h0, -1, 0);
        do_req(1'b0, 8'h13, 2'd0, 32'h0, -1, 0);
        do_req(1'b1, 8'h20, 2'd1, 32'h12345678, -1, 0);
        do_req(1'b1, 8'h22, 2'd0, 32'h12345678, -1, 0);

        // Back-pressure on the second beat.
        do_req(1'b0, 8'hF0, 2'd3, 32'h0, 1, 5);

        // Reset while the first beat of a 4-beat read waits for data.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'hF0;
        req_len   = 2'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_memread", mem_memread, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_memread",    mem_memread, 1'b0);
        check("mid_rst_memwrite",   mem_memwrite, 1'b0);
        check("mid_rst_req_ready",  req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        rd0 = rd_log.size();
        lat = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) lat++;
        end
        check("post_rst_no_resp", lat, 0);
        check("post_rst_no_read", rd_log.size(), rd0);
        do_req(1'b0, 8'h10, 2'd0, 32'h0, -1, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = ($urandom_range(0, 2) == 0);
            l = 2'($urandom_range(0, 3));
            if (w && $urandom_range(0, 7) != 0) l = 2'd0;
            do_req(w, a, l, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                   int'($urandom_range(1, 3)));
        end

        check("strobe_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
